// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor controller.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_sub_ctrl_fs_cell.sv
// One-bit full subtractor: di = a - b - c (mod 2), bo = borrow out. Purely combinational.
module fs_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic di,
  output logic bo
);

  assign di = a ^ b ^ c;
  assign bo = (~a & (b | c)) | (b & c);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial A - B - borrow_in, LSB first, one bit per clock; start->done latency WIDTH+1.
// start is honoured only in IDLE or DONE, so back-to-back operations need no idle gap.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] d_sr_q, d_sr_d;
  logic             brw_q, brw_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bo_q, bo_d;

  logic             cell_di;
  logic             cell_bo;
  logic [WIDTH-1:0] d_shift;
  logic             last_bit;

  fs_cell u_cell (
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .c  (brw_q),
    .di (cell_di),
    .bo (cell_bo)
  );

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // d_shift is built this way so WIDTH=1 needs no zero-width slice.
  always_comb begin
    d_shift            = d_sr_q >> 1;
    d_shift[WIDTH-1]   = cell_di;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    d_sr_d  = d_sr_q;
    brw_d   = brw_q;
    diff_d  = diff_q;
    bo_d    = bo_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          brw_d   = borrow_in;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        d_sr_d = d_shift;
        brw_d  = cell_bo;
        cnt_d  = cnt_q + CW'(1);
        if (last_bit) begin
          // Result registers take the final bit and borrow on this same edge.
          diff_d  = d_shift;
          bo_d    = cell_bo;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      d_sr_q  <= '0;
      brw_q   <= 1'b0;
      diff_q  <= '0;
      bo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      d_sr_q  <= d_sr_d;
      brw_q   <= brw_d;
      diff_q  <= diff_d;
      bo_q    <= bo_d;
    end
  end

  assign busy       = (state_q == ST_SHIFT);
  assign done       = (state_q == ST_DONE);
  assign diff       = diff_q;
  assign borrow_out = bo_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl: WIDTH=8 against a timeline model, WIDTH=1 exhaustively.
module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       bin8 = 1'b0;
  logic       busy8, done8, bo8;
  logic [7:0] diff8;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       bin1 = 1'b0;
  logic       busy1, done1, bo1;
  logic [0:0] diff1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_sub_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .borrow_in(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
  );

  serial_sub_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .borrow_in(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: m_c is the number of clock edges since the accepting edge.
  // busy during m_c=1..W, done at m_c=W+1; a new start is honoured only once m_c>=W+1.
  bit         m_act = 1'b0;
  int         m_c = 0;
  logic [7:0] m_a = '0, m_b = '0;
  logic       m_bin = 1'b0;
  logic [7:0] m_diff = '0;
  logic       m_bo = 1'b0;
  logic       exp_busy, exp_done;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act  <= 1'b0;
      m_c    <= 0;
      m_diff <= '0;
      m_bo   <= 1'b0;
    end else if (start8 && (!m_act || m_c >= W + 1)) begin
      m_act <= 1'b1;
      m_c   <= 1;
      m_a   <= a8;
      m_b   <= b8;
      m_bin <= bin8;
    end else if (m_act) begin
      m_c <= m_c + 1;
      if (m_c + 1 == W + 1) begin
        m_diff <= 8'(int'(m_a) - int'(m_b) - int'(m_bin));
        m_bo   <= (int'(m_a) < int'(m_b) + int'(m_bin));
      end
    end
  end

  assign exp_busy = m_act && (m_c >= 1) && (m_c <= W);
  assign exp_done = m_act && (m_c == W + 1);

  always @(negedge clk) begin
    check("busy8", 32'(busy8), 32'(exp_busy));
    check("done8", 32'(done8), 32'(exp_done));
    check("diff8", 32'(diff8), 32'(m_diff));
    check("borrow8", 32'(bo8), 32'(m_bo));
    check("no_busy_and_done", 32'(busy8 & done8), 32'd0);
  end

  // Pulses start with the given operands; returns cycles to done (-1 on timeout) and busy cycles seen.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                         output int lat, output int nbusy);
    @(negedge clk);
    a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
    lat = -1;
    nbusy = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (busy8) nbusy++;
      if (done8) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin : stim
    int lat, nbusy, ndone, d1, d2;

    #1 rst = 1'b1;
    #1;
    check("reset_busy", 32'(busy8), 32'd0);
    check("reset_done", 32'(done8), 32'd0);
    check("reset_diff", 32'(diff8), 32'd0);
    check("reset_borrow", 32'(bo8), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op8(8'd100, 8'd37, 1'b0, lat, nbusy);
    check("t1_latency", 32'(lat), 32'd9);
    check("t1_busy_cycles", 32'(nbusy), 32'd8);
    check("t1_diff", 32'(diff8), 32'd63);
    check("t1_borrow", 32'(bo8), 32'd0);

    run_op8(8'd5, 8'd9, 1'b0, lat, nbusy);
    check("t2a_latency", 32'(lat), 32'd9);
    check("t2a_diff", 32'(diff8), 32'hFC);
    check("t2a_borrow", 32'(bo8), 32'd1);
    run_op8(8'd0, 8'd0, 1'b1, lat, nbusy);
    check("t2b_diff", 32'(diff8), 32'hFF);
    check("t2b_borrow", 32'(bo8), 32'd1);

    // start re-pulsed mid-operation must be ignored
    @(negedge clk);
    a8 = 8'd10; b8 = 8'd3; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    a8 = 8'd200; b8 = 8'd1; bin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    check("t3_done_count", 32'(ndone), 32'd1);
    check("t3_diff", 32'(diff8), 32'd7);
    check("t3_borrow", 32'(bo8), 32'd0);

    // asynchronous reset in SHIFT cycle 4
    @(negedge clk);
    a8 = 8'd50; b8 = 8'd20; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t4_busy_in_rst", 32'(busy8), 32'd0);
    check("t4_done_in_rst", 32'(done8), 32'd0);
    check("t4_diff_in_rst", 32'(diff8), 32'd0);
    check("t4_borrow_in_rst", 32'(bo8), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    check("t4_no_done", 32'(ndone), 32'd0);
    run_op8(8'd77, 8'd7, 1'b0, lat, nbusy);
    check("t4_after_latency", 32'(lat), 32'd9);
    check("t4_after_diff", 32'(diff8), 32'd70);

    // back-to-back with start held high
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd55; bin8 = 1'b0; start8 = 1'b1;
    d1 = -1;
    d2 = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) begin
        a8 = 8'd55; b8 = 8'd200;
      end
      if (done8) begin
        if (d1 < 0) begin
          d1 = k;
          check("t5_first_diff", 32'(diff8), 32'd145);
          check("t5_first_borrow", 32'(bo8), 32'd0);
        end else begin
          d2 = k;
          check("t5_second_diff", 32'(diff8), 32'd111);
          check("t5_second_borrow", 32'(bo8), 32'd1);
          start8 = 1'b0;
          break;
        end
      end
    end
    start8 = 1'b0;
    check("t5_first_done", 32'(d1), 32'd9);
    check("t5_second_done", 32'(d2), 32'd18);

    // WIDTH=1 exhaustive
    for (int i = 0; i < 8; i++) begin
      int ea, eb, ec;
      ea = (i >> 2) & 1;
      eb = (i >> 1) & 1;
      ec = i & 1;
      @(negedge clk);
      a1 = 1'(ea); b1 = 1'(eb); bin1 = 1'(ec); start1 = 1'b1;
      lat = -1;
      for (int k = 1; k <= 10; k++) begin
        @(negedge clk);
        start1 = 1'b0;
        if (done1) begin
          lat = k;
          break;
        end
      end
      check($sformatf("w1_latency_%0d", i), 32'(lat), 32'd2);
      check($sformatf("w1_diff_%0d", i), 32'(diff1), 32'((ea - eb - ec) & 1));
      check($sformatf("w1_borrow_%0d", i), 32'(bo1), 32'(ea < eb + ec));
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_sub_ctrl.md
# serial_sub_ctrl

Bit-serial N-bit subtractor controller. Computes A − B − borrow_in one bit per clock, LSB first, by sequencing a single full-subtractor cell through shift registers under an FSM. Used where area matters more than latency; it wraps the team's 1-bit full-subtractor cell with a start/done handshake.

## Interface
- WIDTH, 8, operand and result width in bits; legal range ≥ 1.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  minuend; captured on the accepted start.
- b  input  WIDTH  subtrahend; captured on the accepted start.
- borrow_in  input  1  initial borrow; captured on the accepted start.
- busy  output  1  high while bits are being processed (SHIFT state).
- done  output  1  single-cycle pulse when the result becomes valid.
- diff  output  WIDTH  result register, (a − b − borrow_in) mod 2^WIDTH.
- borrow_out  output  1  final borrow; 1 iff a < b + borrow_in (unsigned).

## Operation
- States: IDLE, SHIFT, DONE. Encoding is fixed in the shared package.
- IDLE, start=1 → capture a, b and borrow_in into a_sr, b_sr and brw; clear cnt; go to SHIFT.
- IDLE, start=0 → stay in IDLE.
- SHIFT, each cycle:
  - The cell computes di = a_sr[0]^b_sr[0]^brw and bo = (~a_sr[0]&(b_sr[0]|brw)) | (b_sr[0]&brw).
  - di shifts into the MSB of d_sr. a_sr and b_sr shift right by one. brw ← bo. cnt ← cnt+1.
- SHIFT, when cnt == WIDTH−1 → on that same edge, load the final di into d_sr and go to DONE.
- DONE lasts exactly one cycle:
  - diff ← d_sr (including the last bit) and borrow_out ← the final brw. These registers are written on the SHIFT→DONE edge, so they are visible while done=1.
  - start=1 → capture new operands and go to SHIFT. This allows back-to-back operations.
  - start=0 → go to IDLE.
- start in SHIFT is ignored; it is neither queued nor an error.
- diff and borrow_out change only on the SHIFT→DONE edge. They hold their value through later operations until the next completion.
- cnt width is $clog2(WIDTH+1). This keeps WIDTH=1 legal: in that case SHIFT lasts one cycle.
- rst, at any time and including mid-operation, asynchronously forces:
  - state=IDLE;
  - all shift registers, cnt and brw to 0;
  - busy=0, done=0, diff=0, borrow_out=0.
- An interrupted operation produces no done.

## Timing
- Reset values: busy=0, done=0, diff=0, borrow_out=0.
- Start is accepted at edge 0. busy=1 during cycles 1..WIDTH. done=1 during cycle WIDTH+1.
- Latency from start edge to done: WIDTH+1 cycles.
- The result is valid in the same cycle that done is high.
- busy and done are registered (Moore) outputs. They are never high together.
- Back-to-back: with start held high in the DONE cycle, busy rises on the next cycle. Throughput is one result per WIDTH+1 cycles.
- Inputs a, b and borrow_in are don't-care except on the accepting edge.

## Structure
- Shared package serial_sub_pkg holds:
  - the state typedef (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - the default WIDTH constant.
- The unused state encoding 2'd3 recovers to IDLE.
- Sub-module fs_cell is purely combinational: inputs a, b, c; outputs di, bo. It uses the equations above and is instantiated once.
- The controller holds the FSM, the counter, the shift registers, the borrow flop and the result registers.

## Test plan
- WIDTH=8: a=100, b=37, borrow_in=0, start pulsed → done exactly 9 cycles later, diff=63, borrow_out=0, busy high for exactly 8 cycles.
- WIDTH=8: a=5, b=9 → diff=8'hFC, borrow_out=1. Then a=0, b=0, borrow_in=1 → diff=8'hFF, borrow_out=1.
- start re-pulsed with new operands while busy → ignored; the first result is unchanged and only one done pulse occurs.
- Reset mid-operation:
  - rst asserted asynchronously (not on a clock edge) at SHIFT cycle 4 → all outputs 0 immediately and no done.
  - Next start after reset release → correct result.
- Back-to-back: start held high continuously with a=200/b=55, then a=55/b=200 → done pulses 9 cycles apart; diff=145/borrow_out=0, then diff=111/borrow_out=1.
- WIDTH=1 exhaustive: all 8 combinations of a, b, borrow_in → diff and borrow_out match the 1-bit subtractor truth table, with done 2 cycles after start.
